top_level: RTL and testbench

TOP_LEVEL -- requirements
Module: top_level

---
 rtl/top_level_pkg.sv | 18 +
 rtl/top_level_uart_rx.sv | 77 +++++++
 rtl/top_level.sv | 206 ++++++++++++++++++++
 tb/tb_top_level.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/top_level_pkg.sv
// rtl/top_level_pkg.sv - shared constants, framing states and sample type
// Defaults for the UART link plus the Q8.8 sample format used by the SMA path.
package top_level_pkg;

  localparam int CLK_HZ_DEF = 50_000_000;
  localparam int BAUD_DEF   = 115_200;
  localparam int HDR_BYTES  = 12;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    HDR,
    DATA_LO,
    DATA_HI
  } frame_state_t;

  typedef logic signed [15:0] q8_8_t;

endpackage

// File: rtl/top_level_uart_rx.sv
// rtl/top_level_uart_rx.sv - 8N1 UART receiver with start-bit qualification
// Emits a one-cycle strobe at the stop-bit centre; bytes with a low stop bit are dropped.
module uart_rx
  import top_level_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // [1:0] is the synchronizer, [2] holds the previous synchronized level
  logic [2:0]    r_sync;
  rx_state_t     r_state;
  rx_state_t     w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_data;
  logic          w_rx;
  logic          w_fall;
  logic          w_tick;

  assign w_rx   = r_sync[1];
  assign w_fall = r_sync[2] & ~r_sync[1];
  assign w_tick = (r_state == RX_START) ? (r_cnt == HALF) : (r_cnt == FULL);
  assign o_data = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= 3'b111;
      r_state <= RX_IDLE;
    end else begin
      r_sync  <= {r_sync[1:0], i_rx};
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_bit  <= '0;
      r_data <= '0;
    end else begin
      if (r_state == RX_IDLE || w_tick) r_cnt <= '0;
      else                              r_cnt <= r_cnt + CW'(1);
      if (r_state == RX_DATA && w_tick) begin
        r_data <= {w_rx, r_data[7:1]};
        r_bit  <= r_bit + 3'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_tick) w_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && r_bit == 3'd7) w_next = RX_STOP;
      RX_STOP:  if (w_tick) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_comb begin
    o_valid = (r_state == RX_STOP) && w_tick && w_rx;
  end

endmodule

// File: rtl/top_level.sv
// rtl/top_level.sv - UART framed Q8.8 moving-average filter with TX byte FIFO
// Define TOP_LEVEL_HDR_ECHO_EN to also echo every valid header byte to the transmitter.
module top_level
  import top_level_pkg::*;
#(
  parameter int CLK_HZ   = CLK_HZ_DEF,
  parameter int BAUD     = BAUD_DEF,
  parameter int WIN_LOG2 = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic uart_rx,
  output logic uart_tx
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int WIN = 1 << WIN_LOG2;
  localparam int SW  = 16 + WIN_LOG2;
  localparam int CW  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic [7:0] w_rx_data;
  logic       w_rx_valid;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk   (clk),
    .i_rst   (reset_n),
    .i_rx    (uart_rx),
    .o_data  (w_rx_data),
    .o_valid (w_rx_valid)
  );

  frame_state_t r_state, w_next_state;
  logic [3:0]   r_byte_cnt;
  logic [31:0]  r_len, r_samp_cnt;
  logic [31:0]  w_len_full, w_samp_next;
  logic [7:0]   r_lo;
  logic         w_hdr_byte_v, w_hdr_last, w_lo_v, w_sample_v;
  q8_8_t        w_sample;

  // Last header byte completes the length in the same cycle it arrives
  assign w_len_full  = {w_rx_data, r_len[23:0]};
  assign w_samp_next = r_samp_cnt + 32'd1;
  assign w_sample    = {w_rx_data, r_lo};

  always_ff @(posedge clk) begin
    if (reset_n) r_state <= HDR;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      HDR:     if (w_hdr_last) w_next_state = (w_len_full == 32'd0) ? HDR : DATA_LO;
      DATA_LO: if (w_rx_valid) w_next_state = DATA_HI;
      DATA_HI: if (w_rx_valid) w_next_state = (w_samp_next == r_len) ? HDR : DATA_LO;
      default: w_next_state = HDR;
    endcase
  end

  always_comb begin
    w_hdr_byte_v = (r_state == HDR) && w_rx_valid;
    w_hdr_last   = w_hdr_byte_v && (r_byte_cnt == 4'(HDR_BYTES - 1));
    w_lo_v       = (r_state == DATA_LO) && w_rx_valid;
    w_sample_v   = (r_state == DATA_HI) && w_rx_valid;
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_byte_cnt <= '0;
      r_len      <= '0;
      r_samp_cnt <= '0;
      r_lo       <= '0;
    end else begin
      if (w_hdr_byte_v) begin
        r_byte_cnt <= w_hdr_last ? 4'd0 : r_byte_cnt + 4'd1;
        if (r_byte_cnt[3]) r_len[8*r_byte_cnt[1:0] +: 8] <= w_rx_data;
        r_samp_cnt <= '0;
      end
      if (w_lo_v)     r_lo       <= w_rx_data;
      if (w_sample_v) r_samp_cnt <= w_samp_next;
    end
  end

  q8_8_t                r_hist [WIN];
  logic signed [SW-1:0] r_sum, w_sum_next;
  logic [15:0]          r_sma;
  logic                 r_sma_p1, r_sma_p2, r_hi_pend;

  assign w_sum_next = r_sum + SW'(w_sample) - SW'(r_hist[WIN-1]);

  // Sample -> sum (+1) -> sma (+2, low byte pushed) -> high byte pushed (+3)
  always_ff @(posedge clk) begin
    if (reset_n || w_hdr_last) begin
      for (int i = 0; i < WIN; i++) r_hist[i] <= '0;
      r_sum <= '0;
    end else if (w_sample_v) begin
      for (int i = WIN - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
      r_hist[0] <= w_sample;
      r_sum     <= w_sum_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_sma_p1  <= 1'b0;
      r_sma_p2  <= 1'b0;
      r_hi_pend <= 1'b0;
      r_sma     <= '0;
    end else begin
      r_sma_p1  <= w_sample_v;
      r_sma_p2  <= r_sma_p1;
      r_hi_pend <= r_sma_p2;
      if (r_sma_p1) r_sma <= 16'(r_sum >>> WIN_LOG2);
    end
  end

  logic       w_echo_v;
  logic [7:0] w_echo_d;
`ifdef TOP_LEVEL_HDR_ECHO_EN
  logic       r_echo_v;
  logic [7:0] r_echo_d;
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_echo_v <= 1'b0;
      r_echo_d <= '0;
    end else begin
      r_echo_v <= w_hdr_byte_v;
      r_echo_d <= w_rx_data;
    end
  end
  assign w_echo_v = r_echo_v;
  assign w_echo_d = r_echo_d;
`else
  assign w_echo_v = 1'b0;
  assign w_echo_d = 8'h00;
`endif

  logic          w_push, w_wr, w_pop, w_full, w_empty;
  logic [7:0]    w_push_data;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_count;

  assign w_push      = w_echo_v | r_sma_p2 | r_hi_pend;
  assign w_push_data = w_echo_v ? w_echo_d : (r_sma_p2 ? r_sma[7:0] : r_sma[15:8]);
  assign w_full      = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_wr        = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  logic          r_tx_busy;
  logic [9:0]    r_tx_shift;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic          w_bit_end, w_tx_done;

  assign w_bit_end = r_tx_busy && (r_tx_cnt == FULL);
  assign w_tx_done = w_bit_end && (r_tx_bit == 4'd9);
  // Reload straight from the final stop-bit clock so frames run back-to-back
  assign w_pop     = (!r_tx_busy || w_tx_done) && !w_empty;
  assign uart_tx   = !r_tx_busy || r_tx_shift[0];

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_tx_busy  <= 1'b0;
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
    end else if (w_pop) begin
      r_tx_busy  <= 1'b1;
      r_tx_shift <= {1'b1, r_mem[r_rp], 1'b0};
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
    end else if (w_tx_done) begin
      r_tx_busy <= 1'b0;
    end else if (w_bit_end) begin
      r_tx_shift <= {1'b1, r_tx_shift[9:1]};
      r_tx_cnt   <= '0;
      r_tx_bit   <= r_tx_bit + 4'd1;
    end else if (r_tx_busy) begin
      r_tx_cnt <= r_tx_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_top_level.sv
// tb/tb_top_level.sv - scoreboard bench for the UART SMA filter
// Stimulus pushes expected TX bytes; an independent monitor decodes uart_tx and pops.
module tb_top_level;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;

  logic [7:0] exp_q [$];
  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b1;
  bit  exp_en = 1'b1;
  logic [7:0] mon_d;
  logic       mon_start, mon_stop;

  always #5 clk = ~clk;

  top_level #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WIN_LOG2(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    if (!stop) send_bit(1'b1);
  endtask

  task automatic send_header(input logic [31:0] len, input int bad_at = -1);
    logic [7:0] hdr [12];
    hdr = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
            len[7:0], len[15:8], len[23:16], len[31:24]};
    for (int i = 0; i < 12; i++) begin
      if (i == bad_at) send_byte(8'h55, 1'b0);
`ifdef TOP_LEVEL_HDR_ECHO_EN
      if (exp_en) exp_q.push_back(hdr[i]);
`endif
      send_byte(hdr[i]);
    end
  endtask

  task automatic send_sample(input logic [15:0] s, input logic [15:0] sma);
    send_byte(s[7:0]);
    if (exp_en) begin
      exp_q.push_back(sma[7:0]);
      exp_q.push_back(sma[15:8]);
    end
    send_byte(s[15:8]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Monitor: decode each uart_tx frame at bit centres and compare against the queue
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !reset_n && uart_tx == 1'b0) begin
        repeat (CPB / 2) @(posedge clk);
        #1 mon_start = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1 mon_d[i] = uart_tx;
        end
        repeat (CPB) @(posedge clk);
        #1 mon_stop = uart_tx;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %02h expected none", mon_d);
        end else begin
          check("tx_start_bit", mon_start, 0);
          check("tx_byte", mon_d, exp_q.pop_front());
          check("tx_stop_bit", mon_stop, 1);
        end
      end
    end
  end

  initial begin
    bit saw_low;
    int n;

    repeat (3) @(negedge clk);
    check("reset_tx_idle", uart_tx, 1);
    repeat (3) @(negedge clk);
    check("reset_tx_idle_hold", uart_tx, 1);
    reset_n = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_tx_idle", uart_tx, 1);

    send_header(32'd2);
    send_sample(16'h1900, 16'h0C80);
    send_sample(16'h1A00, 16'h1980);

    send_header(32'd0);
    send_header(32'd1);
    send_sample(16'h0100, 16'h0080);

    send_header(32'd1);
    send_sample(16'hFF00, 16'hFF80);

    send_header(32'd1, 5);
    send_sample(16'h0400, 16'h0200);
    wait_drain("drain_main");

    // Start pulse shorter than half a bit must not produce a byte
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    saw_low = 1'b0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (uart_tx == 1'b0) saw_low = 1'b1;
    end
    check("glitch_no_tx", saw_low, 0);
    send_header(32'd1);
    send_sample(16'h0200, 16'h0100);
    wait_drain("drain_glitch");

    // Reset in the middle of a TX frame aborts it and flushes the FIFO
    mon_en = 1'b0;
    exp_en = 1'b0;
    send_header(32'd1);
    send_sample(16'h0100, 16'h0080);
    n = 0;
    while (uart_tx != 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("midframe_tx_started", uart_tx, 0);
    repeat (3 * CPB) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 check("midframe_reset_tx_high", uart_tx, 1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    saw_low = 1'b0;
    repeat (30 * CPB) begin
      @(negedge clk);
      if (uart_tx == 1'b0) saw_low = 1'b1;
    end
    check("fifo_flushed_by_reset", saw_low, 0);

    mon_en = 1'b1;
    exp_en = 1'b1;
    send_header(32'd1);
    send_sample(16'hFF00, 16'hFF80);
    wait_drain("drain_recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
